// File: rtl/bs_pkg.sv
// Shared types and channel indices for the push-button conditioning front end.
package bs_pkg;

    typedef enum logic [1:0] {
        IDLE_LOW,
        CONFIRM_HIGH,
        HELD_HIGH,
        CONFIRM_LOW
    } btn_st_t;

    localparam int unsigned BTN1_IDX  = 0;
    localparam int unsigned BTN2A_IDX = 1;
    localparam int unsigned BTN2B_IDX = 2;

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: two-flop synchronizer, debounce FSM with counter,
// registered level and single-cycle press pulse.
module btn_debounce_ch
    import bs_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic clr,
    input  logic raw,
    output logic level,
    output logic pulse
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             s1_q, s2_q;
    btn_st_t          state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             pulse_q, pulse_d;

    // State register, including synchronizer and output flops.
    always_ff @(posedge clk) begin
        if (clr) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            state_q <= IDLE_LOW;
            cnt_q   <= '0;
            level_q <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            s1_q    <= raw;
            s2_q    <= s1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            pulse_q <= pulse_d;
        end
    end

    // Next-state: a level change is accepted once the opposite value has been
    // seen with the counter already at CNT_MAX; any contrary sample aborts.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE_LOW: begin
                if (s2_q) begin
                    state_d = CONFIRM_HIGH;
                    cnt_d   = CNT_ONE;
                end
            end
            CONFIRM_HIGH: begin
                if (!s2_q) begin
                    state_d = IDLE_LOW;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = HELD_HIGH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            HELD_HIGH: begin
                if (!s2_q) begin
                    state_d = CONFIRM_LOW;
                    cnt_d   = CNT_ONE;
                end
            end
            CONFIRM_LOW: begin
                if (s2_q) begin
                    state_d = HELD_HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = IDLE_LOW;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE_LOW;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are registered from the upcoming state so they track it exactly.
    always_comb begin
        level_d = (state_d == HELD_HIGH) || (state_d == CONFIRM_LOW);
        pulse_d = (state_q == CONFIRM_HIGH) && (state_d == HELD_HIGH);
    end

    assign level = level_q;
    assign pulse = pulse_q;

endmodule

// File: rtl/btn_conditioner.sv
// Debounce front end for the game-control FSM: N_BTN independent channels
// producing clean levels and single-cycle press pulses.
module btn_conditioner
    import bs_pkg::*;
#(
    parameter int unsigned N_BTN           = 3,
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_pulse
);

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        btn_debounce_ch #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_ch (
            .clk  (clk),
            .clr  (clr),
            .raw  (btn_raw[i]),
            .level(btn_level[i]),
            .pulse(btn_pulse[i])
        );
    end

endmodule

// File: tb/tb_btn_conditioner.sv
// Scoreboard bench for btn_conditioner: directed scenarios plus random bouncing
// against a run-length reference model.
module tb_btn_conditioner;
    import bs_pkg::*;

    localparam int unsigned N = 3;
    localparam int unsigned D = 4;

    logic         clk = 1'b0;
    logic         clr = 1'b1;
    logic [N-1:0] btn_raw = '0;
    logic [N-1:0] btn_level;
    logic [N-1:0] btn_pulse;

    btn_conditioner #(
        .N_BTN          (N),
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .clk      (clk),
        .clr      (clr),
        .btn_raw  (btn_raw),
        .btn_level(btn_level),
        .btn_pulse(btn_pulse)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N-1:0] level;
        logic [N-1:0] pulse;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: raw values reach the debouncer two edges later; a level
    // flips after D+1 consecutive contrary samples.
    logic [N-1:0] m_h1 = '0;
    logic [N-1:0] m_h2 = '0;
    logic [N-1:0] m_level = '0;
    int           m_run[N];
    int           m_pulses = 0;
    int           dut_pulses = 0;

    task automatic model_edge();
        exp_t e;
        e.pulse = '0;
        if (clr) begin
            m_h1    = '0;
            m_h2    = '0;
            m_level = '0;
            for (int i = 0; i < N; i++) m_run[i] = 0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (m_h2[i] != m_level[i]) begin
                    m_run[i]++;
                    if (m_run[i] == D + 1) begin
                        m_level[i] = m_h2[i];
                        m_run[i]   = 0;
                        if (m_h2[i]) e.pulse[i] = 1'b1;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            m_h2 = m_h1;
            m_h1 = btn_raw;
        end
        e.level = m_level;
        m_pulses += $countones(e.pulse);
        exp_q.push_back(e);
    endtask

    task automatic step(input logic [N-1:0] raw, input logic c);
        @(negedge clk);
        btn_raw = raw;
        clr     = c;
        @(posedge clk);
        model_edge();
    endtask

    task automatic hold(input logic [N-1:0] raw, input int n);
        repeat (n) step(raw, 1'b0);
    endtask

    // Monitor: outputs are registered, so every cycle presents a result.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            dut_pulses += $countones(btn_pulse);
            if ({btn_level, btn_pulse} !== e) begin
                n_bad++;
                $display("FAIL cycle_check t=%0t level=%b pulse=%b expected level=%b pulse=%b",
                         $time, btn_level, btn_pulse, e.level, e.pulse);
            end
        end
    end

    initial begin
        logic [N-1:0] b1, b2a, b2b, r;
        b1  = N'(1 << BTN1_IDX);
        b2a = N'(1 << BTN2A_IDX);
        b2b = N'(1 << BTN2B_IDX);
        for (int i = 0; i < N; i++) m_run[i] = 0;

        // Reset state
        step('0, 1'b1);
        step('0, 1'b1);
        hold('0, 5);

        // Clean press and release on BTN1
        hold(b1, 20);
        hold('0, 20);

        // Bounce on BTN2A, then stable high
        step(b2a, 1'b0);
        step('0, 1'b0);
        step(b2a, 1'b0);
        step('0, 1'b0);
        step(b2a, 1'b0);
        hold(b2a, 15);
        hold('0, 15);

        // Long hold with a short drop on BTN2B
        hold(b2b, 50);
        hold('0, 3);
        hold(b2b, 20);
        hold('0, 15);

        // Simultaneous press on all channels
        hold('1, 15);
        hold('0, 15);

        // Reset in the middle of a confirmation, button still held
        hold(b1, 3);
        step(b1, 1'b1);
        hold(b1, 15);
        hold('0, 15);

        // Random bouncing with occasional resets
        r = '0;
        for (int k = 0; k < 2000; k++) begin
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 7) == 0) r[i] = ~r[i];
            step(r, ($urandom_range(0, 99) == 0));
        end
        hold('0, 12);

        @(negedge clk);
        #1;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL queue_drain pending=%0d expected 0", exp_q.size());
        end
        n_cmp++;
        if (dut_pulses != m_pulses) begin
            n_bad++;
            $display("FAIL pulse_total got=%0d expected=%0d", dut_pulses, m_pulses);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
